// File: rtl/reg_desp_n.sv
// Parametrised universal shift register: shift, rotate, parallel load and hold,
// with a saturating serialisation counter and a one-cycle word-done pulse.
module reg_desp_n #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic             ENB,
    input  logic             DIR,
    input  logic             S_IN,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             S_OUT,
    output logic [CNT_W-1:0] COUNT,
    output logic             DONE
);

    typedef enum logic [1:0] {
        MODE_SHIFT  = 2'b00,
        MODE_ROTATE = 2'b01,
        MODE_LOAD   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    logic [WIDTH-1:0] q_reg, q_next;
    logic             s_out_reg, s_out_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             done_reg, done_next;

    // Bit entering the register at the vacated end, and the bit leaving it.
    logic fill_bit;
    logic exit_bit;
    logic is_step;

    always_comb begin
        exit_bit = DIR ? q_reg[WIDTH-1] : q_reg[0];
        fill_bit = (mode_t'(MODE) == MODE_ROTATE) ? exit_bit : S_IN;
    end

    always_comb begin
        q_next     = q_reg;
        s_out_next = s_out_reg;
        count_next = count_reg;
        done_next  = 1'b0;
        is_step    = 1'b0;

        if (ENB) begin
            case (mode_t'(MODE))
                MODE_SHIFT, MODE_ROTATE: begin
                    is_step    = 1'b1;
                    s_out_next = exit_bit;
                    if (DIR) begin
                        q_next = {q_reg[WIDTH-2:0], fill_bit};
                    end else begin
                        q_next = {fill_bit, q_reg[WIDTH-1:1]};
                    end
                end
                MODE_LOAD: begin
                    q_next     = D;
                    s_out_next = 1'b0;
                    count_next = '0;
                end
                default: begin
                end
            endcase
        end

        // DONE accompanies only the WIDTH-1 -> WIDTH transition; saturated steps stay quiet.
        if (is_step && (count_reg < CNT_W'(WIDTH))) begin
            count_next = count_reg + CNT_W'(1);
            done_next  = (count_reg == CNT_W'(WIDTH - 1));
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_L) begin
            q_reg     <= '0;
            s_out_reg <= 1'b0;
            count_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            q_reg     <= q_next;
            s_out_reg <= s_out_next;
            count_reg <= count_next;
            done_reg  <= done_next;
        end
    end

    assign Q     = q_reg;
    assign S_OUT = s_out_reg;
    assign COUNT = count_reg;
    assign DONE  = done_reg;

endmodule

// File: tb/tb_reg_desp_n.sv
// Self-checking bench for reg_desp_n: directed scenarios plus random traffic on
// 8-bit and 4-bit instances against an arithmetic reference model.
module tb_reg_desp_n;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       enb = 1'b0;
    logic       dir = 1'b0;
    logic       s_in = 1'b0;
    logic [1:0] mode = 2'b11;
    logic [7:0] d8 = '0;
    logic [3:0] d4 = '0;

    logic [7:0] q8;
    logic       s8;
    logic [3:0] c8;
    logic       done8;
    logic [3:0] q4;
    logic       s4;
    logic [2:0] c4;
    logic       done4;

    int checks = 0;
    int errors = 0;

    // Reference model state, plain integers
    int m8_q, m8_s, m8_c, m8_d;
    int m4_q, m4_s, m4_c, m4_d;

    always #5 clk = ~clk;

    reg_desp_n #(.WIDTH(8)) dut8 (
        .CLK(clk), .RESET_L(rst_l), .ENB(enb), .DIR(dir), .S_IN(s_in),
        .MODE(mode), .D(d8), .Q(q8), .S_OUT(s8), .COUNT(c8), .DONE(done8)
    );

    reg_desp_n #(.WIDTH(4)) dut4 (
        .CLK(clk), .RESET_L(rst_l), .ENB(enb), .DIR(dir), .S_IN(s_in),
        .MODE(mode), .D(d4), .Q(q4), .S_OUT(s4), .COUNT(c4), .DONE(done4)
    );

    // Word viewed as a number: left = multiply by 2, right = divide by 2.
    task automatic model_update(input int w, input int d, inout int q, inout int s,
                                inout int c, inout int dn);
        int mask;
        int top;
        int msb;
        int lsb;
        int fill;
        bit stepped;
        mask = (1 << w) - 1;
        top = 1 << (w - 1);
        stepped = 1'b0;
        if (!rst_l) begin
            q = 0; s = 0; c = 0; dn = 0;
            return;
        end
        dn = 0;
        if (!enb) return;
        msb = (q / top) % 2;
        lsb = q % 2;
        if (mode == 2'b00 || mode == 2'b01) begin
            stepped = 1'b1;
            if (dir) begin
                fill = (mode == 2'b01) ? msb : int'(s_in);
                s = msb;
                q = (q * 2 + fill) & mask;
            end else begin
                fill = (mode == 2'b01) ? lsb : int'(s_in);
                s = lsb;
                q = q / 2 + fill * top;
            end
        end else if (mode == 2'b10) begin
            q = d & mask;
            s = 0;
            c = 0;
        end
        if (stepped && c < w) begin
            c = c + 1;
            if (c == w) dn = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update(8, int'(d8), m8_q, m8_s, m8_c, m8_d);
        model_update(4, int'(d4), m4_q, m4_s, m4_c, m4_d);
        #1;
    endtask

    task automatic drive(input logic e, input logic [1:0] m, input logic dr, input logic si);
        enb = e; mode = m; dir = dr; s_in = si;
    endtask

    task automatic load8(input logic [7:0] val);
        d8 = val;
        drive(1'b1, 2'b10, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        drive(1'b1, 2'b10, 1'b1, 1'b1);
        d8 = 8'hFF; d4 = 4'hF;
        step(); step();
        rst_l = 1'b1;
        checks++;
        if (q8 !== 8'h00 || s8 !== 1'b0 || c8 !== 4'd0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL reset8: got q=%h s=%b c=%0d done=%b required 00 0 0 0", q8, s8, c8, done8);
        end
        checks++;
        if (q4 !== 4'h0 || s4 !== 1'b0 || c4 !== 3'd0 || done4 !== 1'b0) begin
            errors++;
            $display("FAIL reset4: got q=%h s=%b c=%0d done=%b required 0 0 0 0", q4, s4, c4, done4);
        end
        $display("reset: q8=%h c8=%0d q4=%h c4=%0d", q8, c8, q4, c4);
    endtask

    task automatic test_shift();
        load8(8'hA5);
        drive(1'b1, 2'b00, 1'b1, 1'b0);
        step();
        checks++;
        if (q8 !== 8'h4A || s8 !== 1'b1 || c8 !== 4'd1 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL shift_left: got q=%h s=%b c=%0d done=%b required 4a 1 1 0", q8, s8, c8, done8);
        end
        $display("shift: q8=%h s=%b c=%0d", q8, s8, c8);
    endtask

    task automatic test_rotate();
        load8(8'hA5);
        drive(1'b1, 2'b01, 1'b0, 1'b0);
        step();
        checks++;
        if (q8 !== 8'hD2 || s8 !== 1'b1) begin
            errors++;
            $display("FAIL rotate_right: got q=%h s=%b required d2 1", q8, s8);
        end
        $display("rotate right: q8=%h s=%b", q8, s8);
        drive(1'b1, 2'b01, 1'b1, 1'b1);
        step();
        checks++;
        if (q8 !== 8'hA5 || s8 !== 1'b1 || c8 !== 4'd2) begin
            errors++;
            $display("FAIL rotate_left: got q=%h s=%b c=%0d required a5 1 2", q8, s8, c8);
        end
        $display("rotate left: q8=%h s=%b c=%0d", q8, s8, c8);
    endtask

    task automatic test_serialize();
        logic [7:0] exp_s;
        exp_s = 8'b1000_0001;
        load8(8'h81);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'b00, 1'b0, 1'b1);
            step();
            checks++;
            if (s8 !== exp_s[i] || done8 !== (i == 7) || c8 !== 4'(i + 1)) begin
                errors++;
                $display("FAIL serialize_%0d: got s=%b done=%b c=%0d required %b %b %0d",
                         i, s8, done8, c8, exp_s[i], (i == 7), i + 1);
            end
            $display("serialize %0d: q8=%h s=%b c=%0d done=%b", i, q8, s8, c8, done8);
        end
        checks++;
        if (q8 !== 8'hFF) begin
            errors++;
            $display("FAIL serialize_final: got q=%h required ff", q8);
        end
        step();
        checks++;
        if (c8 !== 4'd8 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL saturate: got c=%0d done=%b required 8 0", c8, done8);
        end
        $display("saturate: c8=%0d done=%b", c8, done8);
    endtask

    task automatic test_freeze();
        load8(8'h3C);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b00, 1'b1, 1'b1);
            step();
        end
        // 3C shifted left with ones: 79, F3, E7; last bit out is 1
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1'b0, 2'(i), 1'(i), 1'b1);
            else drive(1'b1, 2'b11, 1'b0, 1'b1);
            d8 = 8'h55;
            step();
            checks++;
            if (q8 !== 8'hE7 || s8 !== 1'b1 || c8 !== 4'd3 || done8 !== 1'b0) begin
                errors++;
                $display("FAIL freeze_%0d: got q=%h s=%b c=%0d done=%b required e7 1 3 0",
                         i, q8, s8, c8, done8);
            end
            $display("freeze %0d: q8=%h s=%b c=%0d", i, q8, s8, c8);
        end
    endtask

    task automatic test_reset_mid();
        load8(8'h5A);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'b00, 1'b0, 1'b1);
            step();
        end
        rst_l = 1'b0;
        d8 = 8'hFF;
        drive(1'b1, 2'b10, 1'b0, 1'b0);
        step();
        rst_l = 1'b1;
        checks++;
        if (q8 !== 8'h00 || s8 !== 1'b0 || c8 !== 4'd0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got q=%h s=%b c=%0d done=%b required 00 0 0 0", q8, s8, c8, done8);
        end
        $display("reset mid: q8=%h c8=%0d", q8, c8);
    endtask

    task automatic test_width4_rotate();
        d4 = 4'h9;
        drive(1'b1, 2'b10, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b01, 1'b1, 1'b0);
            step();
            checks++;
            if (done4 !== (i == 3)) begin
                errors++;
                $display("FAIL w4_done_%0d: got %b required %b", i, done4, (i == 3));
            end
            $display("w4 rotate %0d: q4=%h s=%b done=%b", i, q4, s4, done4);
        end
        checks++;
        if (q4 !== 4'h9 || c4 !== 3'd4) begin
            errors++;
            $display("FAIL w4_rotate: got q=%h c=%0d required 9 4", q4, c4);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            rst_l = ($urandom_range(0, 39) != 0);
            drive(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            d8 = 8'($urandom);
            d4 = 4'($urandom);
            step();
            checks++;
            if (int'(q4) != m4_q || int'(s4) != m4_s || int'(c4) != m4_c || int'(done4) != m4_d) begin
                errors++;
                $display("FAIL rand4_%0d: got q=%h s=%b c=%0d done=%b required %h %0d %0d %0d",
                         i, q4, s4, c4, done4, m4_q, m4_s, m4_c, m4_d);
            end
            checks++;
            if (int'(q8) != m8_q || int'(s8) != m8_s || int'(c8) != m8_c || int'(done8) != m8_d) begin
                errors++;
                $display("FAIL rand8_%0d: got q=%h s=%b c=%0d done=%b required %h %0d %0d %0d",
                         i, q8, s8, c8, done8, m8_q, m8_s, m8_c, m8_d);
            end
            $display("rand %0d: mode=%0d dir=%b q4=%h s4=%b q8=%h s8=%b", i, mode, dir, q4, s4, q8, s8);
        end
        rst_l = 1'b1;
    endtask

    initial begin
        m8_q = 0; m8_s = 0; m8_c = 0; m8_d = 0;
        m4_q = 0; m4_s = 0; m4_c = 0; m4_d = 0;
        test_reset();
        test_shift();
        test_rotate();
        test_serialize();
        test_freeze();
        test_reset_mid();
        test_width4_rotate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
